// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, parity modes and the default
// baud divider used by the baud generator.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // 50 MHz / 115200 baud, rounded to the nearest integer
    localparam int BAUD_DIV_DEFAULT = 434;

    // Unused upper data bits must be zero so they do not disturb the XOR
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Valid/ready byte handshake between a byte producer and the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/baud_tick_det.sv
// Turns the baud generator's square wave into a one-cycle tick per bit period.
module baud_tick_det (
    input  logic clk,
    input  logic srst,
    input  logic baud_clk,
    output logic tick
);
    logic baud_d_reg;

    // Resetting high means a baud_clk already high at release is not an edge
    always_ff @(posedge clk) begin
        if (srst) begin
            baud_d_reg <= 1'b1;
        end else begin
            baud_d_reg <= baud_clk;
        end
    end

    assign tick = baud_clk & ~baud_d_reg;
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// serialiser that advances once per baud tick, with back-to-back frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic      sys_clk,
    input  logic      rst,
    input  logic      baud_clk,
    uart_tx_if.slave  tx,
    output logic      txd,
    output logic      tx_busy
);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);

    logic                 tick;
    tx_state_e            state_reg, state_next;
    logic [DATA_BITS-1:0] hold_reg, hold_next;
    logic                 hold_valid_reg, hold_valid_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_reg, par_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [0:0]           stop_cnt_reg, stop_cnt_next;
    logic                 txd_reg, txd_next;
    logic                 load;
    logic                 accept;
    logic [7:0]           hold_ext;

    baud_tick_det u_tick (
        .clk      (sys_clk),
        .srst     (rst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_ext
        if (gi < DATA_BITS) begin : g_bit
            assign hold_ext[gi] = hold_reg[gi];
        end else begin : g_pad
            assign hold_ext[gi] = 1'b0;
        end
    end

    assign accept = tx.tx_valid & ~hold_valid_reg;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        par_next      = par_reg;
        bit_idx_next  = bit_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        txd_next      = txd_reg;
        load          = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_IDLE: begin
                    if (hold_valid_reg) begin
                        load       = 1'b1;
                        txd_next   = 1'b0;
                        state_next = ST_START;
                    end else begin
                        txd_next = 1'b1;
                    end
                end
                ST_START: begin
                    txd_next     = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = 3'd0;
                    state_next   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_idx_reg == LAST_BIT) begin
                        if (PARITY != PARITY_NONE) begin
                            txd_next   = par_reg;
                            state_next = ST_PARITY;
                        end else begin
                            txd_next      = 1'b1;
                            stop_cnt_next = 1'b0;
                            state_next    = ST_STOP;
                        end
                    end else begin
                        txd_next     = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
                ST_PARITY: begin
                    txd_next      = 1'b1;
                    stop_cnt_next = 1'b0;
                    state_next    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt_reg == LAST_STOP) begin
                        // A held byte starts right after the last stop bit, no idle gap
                        if (hold_valid_reg) begin
                            load       = 1'b1;
                            txd_next   = 1'b0;
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    txd_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            endcase
        end

        if (load) begin
            shift_next = hold_reg;
            par_next   = calc_parity(hold_ext, PARITY);
        end
    end

    always_comb begin
        hold_valid_next = hold_valid_reg;
        hold_next       = hold_reg;
        if (load) begin
            hold_valid_next = 1'b0;
        end else if (accept) begin
            hold_valid_next = 1'b1;
            hold_next       = tx.tx_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            bit_idx_reg    <= 3'd0;
            stop_cnt_reg   <= 1'b0;
            txd_reg        <= 1'b1;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            hold_valid_reg <= hold_valid_next;
            shift_reg      <= shift_next;
            par_reg        <= par_next;
            bit_idx_reg    <= bit_idx_next;
            stop_cnt_reg   <= stop_cnt_next;
            txd_reg        <= txd_next;
        end
    end

    assign tx.tx_ready = ~hold_valid_reg;
    assign txd         = txd_reg;
    assign tx_busy     = (state_reg != ST_IDLE) | hold_valid_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four configurations (8N1, 8E2, 8O2, 5N1) share one
// baud wave; expected frames are queued on accept and checked by per-DUT monitors.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NDUT  = 4;
    localparam int LIMIT = 40000;

    function automatic int cfg_db(input int d);
        return (d == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int d);
        case (d)
            1:       return PARITY_EVEN;
            2:       return PARITY_ODD;
            default: return PARITY_NONE;
        endcase
    endfunction
    function automatic int cfg_stop(input int d);
        return (d == 1 || d == 2) ? 2 : 1;
    endfunction

    typedef struct {
        int          dut;
        logic [15:0] bits;   // line bits in transmission order, bit 0 first
        int          len;
        bit          nogap;  // must start on the tick right after the previous stop bit
        int          start;  // otherwise: required tick index of the start bit
    } frame_t;

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_clk = 1'b0;
    logic       valid [NDUT];
    logic [7:0] data  [NDUT];
    logic       ready [NDUT];
    logic       txd   [NDUT];
    logic       busy  [NDUT];

    int     n_checks = 0;
    int     n_errors = 0;
    frame_t exp_q[$];

    int half = 4;
    int baud_cnt = 0;
    bit rise_pending = 1'b0;
    bit tick_now = 1'b0;
    int tick_cnt = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference frame from the framing rules, built with plain arithmetic
    function automatic frame_t model(input int d, input logic [7:0] b, input bit nogap);
        frame_t f;
        int     db   = cfg_db(d);
        int     word = int'(b) % (1 << db);
        int     ones = $countones(word);
        int     pos  = 1 + db;
        word = word << 1;
        if (cfg_par(d) == PARITY_EVEN) begin
            word = word | ((ones % 2) << pos);
            pos++;
        end else if (cfg_par(d) == PARITY_ODD) begin
            word = word | ((1 - ones % 2) << pos);
            pos++;
        end
        word = word | (((1 << cfg_stop(d)) - 1) << pos);
        f.dut   = d;
        f.bits  = 16'(word);
        f.len   = pos + cfg_stop(d);
        f.nogap = nogap;
        f.start = 0;
        return f;
    endfunction

    function automatic frame_t fixed(input int d, input logic [15:0] bits, input int len, input bit nogap);
        frame_t f;
        f.dut = d; f.bits = bits; f.len = len; f.nogap = nogap; f.start = 0;
        return f;
    endfunction

    initial forever #5 sys_clk = ~sys_clk;

    // baud_clk toggles every 'half' cycles on the falling edge; tick_now marks the
    // rising sys_clk edge at which the DUT sees the new baud rise.
    initial begin
        forever begin
            @(negedge sys_clk);
            baud_cnt++;
            if (baud_cnt >= half) begin
                baud_cnt = 0;
                baud_clk = ~baud_clk;
                if (baud_clk) rise_pending = 1'b1;
            end
            @(posedge sys_clk);
            tick_now     = rise_pending;
            rise_pending = 1'b0;
            if (tick_now) tick_cnt++;
        end
    end

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DB = cfg_db(gi);

        uart_tx_if #(.DATA_BITS(DB)) bus ();

        assign bus.tx_valid = valid[gi];
        assign bus.tx_data  = data[gi][DB-1:0];
        assign ready[gi]    = bus.tx_ready;

        uart_tx #(
            .DATA_BITS (DB),
            .PARITY    (cfg_par(gi)),
            .STOP_BITS (cfg_stop(gi))
        ) dut (
            .sys_clk  (sys_clk),
            .rst      (rst),
            .baud_clk (baud_clk),
            .tx       (bus),
            .txd      (txd[gi]),
            .tx_busy  (busy[gi])
        );

        initial begin : mon
            frame_t      cur;
            logic [15:0] got;
            logic [15:0] mask;
            int          pos;
            bit          in_frame;
            bit          ignore;
            int          last_end;
            logic        prev;
            logic        s;
            bit          r;
            in_frame = 1'b0; ignore = 1'b0; pos = 0; last_end = -100; prev = 1'b1; got = '1;
            cur = fixed(gi, 16'h0, 1, 1'b0);
            forever begin
                @(posedge sys_clk);
                r = rst;
                #1;
                s = txd[gi];
                if (r) begin
                    in_frame = 1'b0;
                    last_end = -100;
                end else if (!tick_now) begin
                    if (s !== prev)
                        check(1'b0, $sformatf("dut%0d_change_off_tick", gi), longint'(s), longint'(prev));
                end else if (in_frame) begin
                    got[pos] = s;
                    pos++;
                    if (pos == cur.len) begin
                        in_frame = 1'b0;
                        last_end = tick_cnt;
                        if (!ignore) begin
                            mask = 16'((32'd1 << cur.len) - 1);
                            check(((got ^ cur.bits) & mask) == 16'h0, $sformatf("dut%0d_frame", gi),
                                  longint'(got & mask), longint'(cur.bits & mask));
                            check(busy[gi] == 1'b1, $sformatf("dut%0d_busy_in_stop", gi), longint'(busy[gi]), 1);
                            $display("dut%0d frame done at tick %0d: bits=%h len=%0d", gi, tick_cnt, got & mask, cur.len);
                        end
                    end
                end else if (s == 1'b0) begin
                    got = '1; got[0] = 1'b0; pos = 1; in_frame = 1'b1;
                    if (exp_q.size() == 0 || exp_q[0].dut != gi) begin
                        check(1'b0, $sformatf("dut%0d_unexpected_frame", gi), longint'(tick_cnt), 0);
                        ignore  = 1'b1;
                        cur.len = 1 + cfg_db(gi) + ((cfg_par(gi) != PARITY_NONE) ? 1 : 0) + cfg_stop(gi);
                    end else begin
                        ignore = 1'b0;
                        cur    = exp_q.pop_front();
                        if (cur.nogap)
                            check(tick_cnt == last_end + 1, $sformatf("dut%0d_no_gap", gi), tick_cnt, last_end + 1);
                        else
                            check(tick_cnt == cur.start, $sformatf("dut%0d_start_tick", gi), tick_cnt, cur.start);
                    end
                end else if (tick_cnt == last_end + 1 && exp_q.size() == 0) begin
                    check(busy[gi] == 1'b0, $sformatf("dut%0d_busy_after_stop", gi), longint'(busy[gi]), 0);
                end
                prev = s;
            end
        end
    end

    task automatic send(input int d, input logic [7:0] b, input frame_t f, input bit push, output int acc);
        int     n = 0;
        frame_t e = f;
        @(negedge sys_clk);
        valid[d] = 1'b1;
        data[d]  = b;
        while (!ready[d] && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        check(ready[d] == 1'b1, $sformatf("dut%0d_ready_wait", d), longint'(ready[d]), 1);
        @(posedge sys_clk);
        #1;
        valid[d] = 1'b0;
        acc = tick_cnt;
        if (push && n < LIMIT) begin
            e.start = tick_cnt + 1;
            exp_q.push_back(e);
        end
        $display("send dut%0d byte %h at tick %0d", d, b, acc);
    endtask

    task automatic wait_drain(input int d);
        int n = 0;
        @(negedge sys_clk);
        while ((exp_q.size() != 0 || busy[d]) && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= LIMIT) begin
            check(1'b0, $sformatf("dut%0d_drain_timeout", d), exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          a, a1, a2, n, blen;
        logic [7:0]  b;
        for (int d = 0; d < NDUT; d++) begin
            valid[d] = 1'b0;
            data[d]  = 8'h00;
        end
        rst = 1'b1;
        repeat (5) @(negedge sys_clk);
        for (int d = 0; d < NDUT; d++) begin
            check(txd[d] == 1'b1, $sformatf("dut%0d_reset_txd", d), longint'(txd[d]), 1);
            check(ready[d] == 1'b1, $sformatf("dut%0d_reset_ready", d), longint'(ready[d]), 1);
            check(busy[d] == 1'b0, $sformatf("dut%0d_reset_busy", d), longint'(busy[d]), 0);
        end
        rst = 1'b0;
        repeat (10) @(negedge sys_clk);

        // Directed frames with hand-derived bit patterns
        send(0, 8'hA5, fixed(0, 16'b1101001010, 10, 1'b0), 1'b1, a);
        wait_drain(0);
        send(0, 8'h55, fixed(0, 16'b1010101010, 10, 1'b0), 1'b1, a1);
        send(0, 8'h0F, fixed(0, 16'b1000011110, 10, 1'b1), 1'b1, a2);
        check(a2 == a1 + 1, "ready_during_start_bit", a2, a1 + 1);
        wait_drain(0);
        send(1, 8'h07, fixed(1, 16'b111000001110, 12, 1'b0), 1'b1, a);
        wait_drain(1);
        send(2, 8'h07, fixed(2, 16'b110000001110, 12, 1'b0), 1'b1, a);
        wait_drain(2);
        send(3, 8'h1B, fixed(3, 16'b1110110, 7, 1'b0), 1'b1, a);
        wait_drain(3);

        // Random bursts against the reference model
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 6; k++) begin
                blen = $urandom_range(1, 3);
                for (int j = 0; j < blen; j++) begin
                    b = 8'($urandom_range(0, 255));
                    send(d, b, model(d, b, j > 0), 1'b1, a);
                end
                wait_drain(d);
                repeat ($urandom_range(0, 12)) @(negedge sys_clk);
            end
        end

        // Reset during DATA with a second byte held
        send(0, 8'h3C, model(0, 8'h3C, 1'b0), 1'b1, a);
        n = 0;
        while (tick_cnt < a + 3 && n < LIMIT) begin
            @(negedge sys_clk);
            n++;
        end
        send(0, 8'hC3, model(0, 8'hC3, 1'b1), 1'b0, a1);
        @(negedge sys_clk);
        rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check(txd[0] == 1'b1, "midframe_reset_txd", longint'(txd[0]), 1);
        check(ready[0] == 1'b1, "midframe_reset_ready", longint'(ready[0]), 1);
        check(busy[0] == 1'b0, "midframe_reset_busy", longint'(busy[0]), 0);
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (300) @(negedge sys_clk);
        check(txd[0] == 1'b1, "after_reset_line_idle", longint'(txd[0]), 1);
        check(busy[0] == 1'b0, "after_reset_not_busy", longint'(busy[0]), 0);
        exp_q.delete();

        // Reset released while baud_clk is high: first frame waits for the next rise
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (!tick_now && n < LIMIT);
        @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check(baud_clk == 1'b1, "baud_high_at_release", longint'(baud_clk), 1);
        b = 8'($urandom_range(0, 255));
        send(0, b, model(0, b, 1'b0), 1'b1, a);
        wait_drain(0);

        // Realistic bit period: baud_clk toggling every 217 cycles
        half = 217;
        repeat (500) @(negedge sys_clk);
        send(0, 8'hA5, fixed(0, 16'b1101001010, 10, 1'b0), 1'b1, a);
        for (int j = 0; j < 2; j++) begin
            b = 8'($urandom_range(0, 255));
            send(0, b, model(0, b, 1'b1), 1'b1, a);
        end
        wait_drain(0);
        repeat (20) @(negedge sys_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serialising UART transmitter on the `sys_clk` domain, directly downstream of the baud generator. It consumes that generator's `baud_clk` square wave (one full period per bit, 115200 baud from 50 MHz). It accepts bytes over a valid/ready handshake into a one-entry holding register. It drives `txd` with start, data LSB-first, optional parity and stop bits, and sends back-to-back frames with no idle gap.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: legal 1 or 2.
- `sys_clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `baud_clk` in 1: baud square wave from the generator; synchronous to `sys_clk`.
- `tx_data` in DATA_BITS: byte to send; sampled on accept.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register empty; a transfer occurs when `tx_valid && tx_ready`.
- `txd` out 1: serial line, idle high, registered.
- `tx_busy` out 1: a frame is in flight or a byte is held.

## Operation
- **Tick**
  - `baud_d` registers `baud_clk`; reset value 1, so a high `baud_clk` at reset release gives no spurious edge.
  - `tick = baud_clk & ~baud_d`: one `sys_clk` cycle per bit period.
- **Holding register**
  - `hold`/`hold_valid`; `tx_ready = ~hold_valid`, which is purely registered.
  - On accept: `hold <= tx_data`, `hold_valid <= 1`.
  - `hold_valid` clears when the FSM loads the shifter.
  - A cycle that clears `hold_valid` cannot also accept, because `tx_ready` was low in that cycle.
- **FSM**: states IDLE, START, DATA, PARITY, STOP. All transitions occur only on `tick`.
  - IDLE: if `hold_valid`, load the shifter, compute the parity bit, clear `hold_valid`, `txd <= 0`, go to START. Otherwise `txd` stays 1.
  - START → DATA: `txd <= shift[0]`, shift right, `bit_idx <= 0`.
  - DATA: if `bit_idx == DATA_BITS-1`, go to PARITY (`txd <= par`) when `PARITY != 0`, else to STOP (`txd <= 1`). Otherwise `txd <= shift[0]`, shift, `bit_idx++`.
  - PARITY → STOP: `txd <= 1`, `stop_cnt <= 0`.
  - STOP: if `stop_cnt == STOP_BITS-1`, then if `hold_valid` load and go to START with `txd <= 0` (no gap); else go to IDLE. Otherwise `stop_cnt++`.
- **Parity**: even = XOR of the data bits; odd = its inverse. Computed over the `DATA_BITS` bits only.
- **Busy**: `tx_busy = (state != IDLE) | hold_valid`.
- **Reset values**
  - `txd` = 1, `tx_busy` = 0, `tx_ready` = 1, state IDLE, counters 0, `baud_d` = 1.
- **Reset mid-frame**: the frame is truncated, `txd` is high on the next edge, and the held byte is discarded.
- **Unsupported input**: `tx_valid` deasserting before ready carries no obligation.

## Timing
- Each line bit lasts exactly one `baud_clk` period (434 `sys_clk` cycles at 50 MHz/115200).
- `txd` changes at the `sys_clk` edge where `tick` = 1, i.e. one cycle after `baud_clk` rises.
- Accept to start-bit edge: from 1 cycle up to one bit period + 1 cycle (waits for the next tick).
- Frame length: 1 + DATA_BITS + (PARITY ? 1 : 0) + STOP_BITS ticks; 8N1 = 10 ticks = 4340 cycles.
- `tx_ready` returns high the cycle after the FSM consumes `hold`. This lets a second byte queue during the first frame's start bit, so sustained throughput is 1 byte per frame time.

## Structure
- `uart_pkg` holds:
  - the state enum (IDLE..STOP);
  - `PARITY_NONE`/`PARITY_ODD`/`PARITY_EVEN` constants;
  - the default baud divider constant shared with the generator.
- Sub-module `baud_tick_det` contains the `baud_d` register and edge AND and outputs `tick`; the receiver reuses it.
- Everything else is flat in `uart_tx`.

## Test plan
Bench drives `baud_clk` toggling every 4 `sys_clk` cycles (bit = 8 cycles), plus one run with every-217-cycle toggling.
- **8N1 single byte**: send 0xA5 → `txd` = 0,1,0,1,0,0,1,0,1,1, each 8 cycles. `tx_busy` falls on the tick ending the stop bit.
- **Back-to-back**: 0x55 then 0x0F with `tx_valid` held → second `tx_ready` high during the first frame. The second start bit immediately follows the first stop bit: 20 contiguous bits, no idle.
- **Parity and stop bits**:
  - `PARITY=2`, `STOP_BITS=2`, byte 0x07 → parity bit 1 and 12 bits total.
  - `PARITY=1`, same byte → parity bit 0.
- **DATA_BITS=5**: byte 0x1B → data bits 1,1,0,1,1, then stop.
- **Reset mid-frame**: `rst` for 1 cycle during the DATA state with a byte held → `txd` = 1 and `tx_ready` = 1 on the next edge. No further frame is emitted; the held byte is lost.
- **Reset release with `baud_clk` high** → no tick; the first frame starts only after the next `baud_clk` rising edge.
